// File: rtl/seq_demux_lanes_pkg.sv
// Shared defaults and lane-data type for the 1:N lane demux and the 32:1 selector mux.
package mux_pkg;
  localparam int DEF_DATA_W    = 2;
  localparam int DEF_NUM_LANES = 32;
  localparam int DEF_SEL_W     = 5;

  typedef logic [DEF_DATA_W-1:0] lane_t;
endpackage

// File: rtl/seq_demux_lanes_lane.sv
// One lane holding register with its valid flag; a write wins over an ack in the same cycle.
module demux_lane
  import mux_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              ack,
  output logic [DATA_W-1:0] data,
  output logic              valid
);

  // Data is kept after an ack so the lane stays stable for late observers.
  always_ff @(posedge clk) begin
    if (reset) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (wr_en) begin
      data  <= wr_data;
      valid <= 1'b1;
    end else if (ack) begin
      valid <= 1'b0;
    end else begin
      valid <= valid;
    end
  end

endmodule

// File: rtl/seq_demux_lanes.sv
// Registered 1:N demux with per-lane valid/ack; define AUTO_SEL_EN to build the
// round-robin target pointer selected by auto_mode.
module seq_demux_lanes
  import mux_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int NUM_LANES = DEF_NUM_LANES,
  parameter int SEL_W     = DEF_SEL_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DATA_W-1:0]           inp,
  input  logic                        inp_valid,
  output logic                        inp_ready,
  input  logic [SEL_W-1:0]            sel,
  input  logic                        auto_mode,
  output logic [NUM_LANES*DATA_W-1:0] out_bus,
  output logic [NUM_LANES-1:0]        out_valid,
  input  logic [NUM_LANES-1:0]        out_ack,
  output logic [SEL_W:0]              out_count,
  output logic                        sel_err
);

  logic [SEL_W-1:0]     tgt;
  logic [NUM_LANES-1:0] hit;
  logic [NUM_LANES-1:0] wr_en;
  logic [NUM_LANES-1:0] next_valid;
  logic                 in_range;
  logic                 accept;
  logic [SEL_W:0]       count_next;

`ifdef AUTO_SEL_EN
  logic [SEL_W-1:0] ptr;

  always_comb begin
    if (auto_mode) begin
      tgt = ptr;
    end else begin
      tgt = sel;
    end
  end

  // The pointer only advances on an accepted auto-mode word, so it never skips a full lane.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (auto_mode && accept) begin
      if (ptr == SEL_W'(NUM_LANES - 1)) begin
        ptr <= '0;
      end else begin
        ptr <= ptr + {{(SEL_W-1){1'b0}}, 1'b1};
      end
    end else begin
      ptr <= ptr;
    end
  end
`else
  logic unused_auto_mode;
  assign unused_auto_mode = auto_mode;

  always_comb begin
    tgt = sel;
  end
`endif

  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      hit[i] = (tgt == SEL_W'(i));
    end
  end

  assign in_range = |hit;

  // Out-of-range targets are always ready so the word can be dropped and flagged.
  always_comb begin
    if (reset) begin
      inp_ready = 1'b0;
    end else if (!in_range) begin
      inp_ready = 1'b1;
    end else begin
      inp_ready = |(hit & (~out_valid | out_ack));
    end
  end

  assign accept     = inp_valid & inp_ready;
  assign wr_en      = hit & {NUM_LANES{accept}};
  assign next_valid = wr_en | (out_valid & ~out_ack);

  always_comb begin
    count_next = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      count_next = count_next + {{SEL_W{1'b0}}, next_valid[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_count <= '0;
      sel_err   <= 1'b0;
    end else begin
      out_count <= count_next;
      sel_err   <= accept & ~in_range;
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    demux_lane #(
      .DATA_W(DATA_W)
    ) u_lane (
      .clk    (clk),
      .reset  (reset),
      .wr_en  (wr_en[g]),
      .wr_data(inp),
      .ack    (out_ack[g]),
      .data   (out_bus[g*DATA_W +: DATA_W]),
      .valid  (out_valid[g])
    );
  end

endmodule
